obi_boot_loader: RTL and testbench

OBI initiator that fills on-chip SRAM from an external byte stream at boot. It accepts bytes over a valid/ready handshake, packs them little-endian into 32-bit words, and issues one OBI write per word to the SRAM data port, starting at the SRAM base address. It sits in front of the SRAM data-port mux, on the opposite side of the bus from the SRAM wrapper. It reports progress, completion and bus errors to the boot controller.

---
 rtl/obi_boot_loader.sv | 152 +++++++++++++++
 tb/tb_obi_boot_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_boot_loader.sv
// OBI boot loader: packs a byte stream little-endian into 32-bit words and
// writes them to SRAM one OBI transaction at a time, starting at BASE_ADDR.
module obi_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned MAX_WORDS = 6144,
    parameter int unsigned LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             req_o,
    input  logic             gnt_i,
    output logic [31:0]      addr_o,
    output logic             we_o,
    output logic [3:0]       be_o,
    output logic [31:0]      wdata_o,
    input  logic             rvalid_i,
    input  logic [31:0]      rdata_i,
    input  logic             illegal_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] count_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_REQ     = 3'd2,
        S_WAIT_RV = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    state_e           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;
    logic [1:0]       byte_idx_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             byte_ready_q;
    logic             req_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             rdata_unused_s;

    assign count_d        = count_q + LEN_W'(1);
    assign rdata_unused_s = ^rdata_i;

    // Load sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            count_q      <= '0;
            byte_idx_q   <= 2'd0;
            addr_q       <= BASE_ADDR;
            wdata_q      <= 32'h0000_0000;
            byte_ready_q <= 1'b0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        count_q    <= '0;
                        addr_q     <= BASE_ADDR;
                        len_q      <= len_i;
                        byte_idx_q <= 2'd0;
                        if (len_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (len_i > MAX_LEN) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q      <= S_COLLECT;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (byte_valid_i && byte_ready_q) begin
                        wdata_q[{byte_idx_q, 3'b000} +: 8] <= byte_data_i;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_q      <= S_REQ;
                            byte_ready_q <= 1'b0;
                            req_q        <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT_RV;
                        if (illegal_i) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_WAIT_RV: begin
                    if (rvalid_i) begin
                        count_q <= count_d;
                        // Address only advances when another word follows, so it
                        // never points past the last SRAM word.
                        if (err_q || (count_d == len_q)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q       <= addr_q + 32'd4;
                            state_q      <= S_COLLECT;
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b0;
                    req_q        <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign req_o        = req_q;
    assign we_o         = req_q;
    assign be_o         = 4'hF;
    assign addr_o       = addr_q;
    assign wdata_o      = wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_obi_boot_loader.sv
// Bench for obi_boot_loader: drives a byte stream and an SRAM-like OBI
// responder, and compares the observed writes against a stream-level model.
module tb_obi_boot_loader;

    localparam int          MAXW = 6144;
    localparam int          LW   = 13;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_data_i = 8'h00;
    logic          byte_ready_o;
    logic          req_o;
    logic          gnt_i = 1'b0;
    logic [31:0]   addr_o;
    logic          we_o;
    logic [3:0]    be_o;
    logic [31:0]   wdata_o;
    logic          rvalid_i = 1'b0;
    logic [31:0]   rdata_i = 32'hDEAD_BEEF;
    logic          illegal_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [LW-1:0] count_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  stream[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_n, exp_count, last_acc, done_at, req_run_max;
    logic        exp_err;

    obi_boot_loader dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .req_o(req_o), .gnt_i(gnt_i),
        .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .illegal_i(illegal_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic fill_stream(input int nbytes);
        stream.delete();
        for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: word i lands at BASE+4i holding stream bytes 4i..4i+3 LSB first;
    // an illegal grant ends the load after that word.
    task automatic ref_model(input int len, input int ill_word);
        exp_addr.delete();
        exp_data.delete();
        if (len == 0) begin
            exp_n = 0; exp_err = 1'b0;
        end else if (len > MAXW) begin
            exp_n = 0; exp_err = 1'b1;
        end else if (ill_word >= 0 && ill_word < len) begin
            exp_n = ill_word + 1; exp_err = 1'b1;
        end else begin
            exp_n = len; exp_err = 1'b0;
        end
        exp_count = exp_n;
        for (int i = 0; i < exp_n; i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back({stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]});
        end
    endtask

    // Drives one load from start pulse to done; acts as stream source and responder.
    task automatic run_load(input int len, input int bubble_pct, input int gmin, input int gmax,
                            input int ill_word, input bit spur_rv, input bit busy_start);
        int sent = 0, cyc = 0, d = -1, grants = 0, req_run = 0;
        bit rv_pend = 1'b0;
        logic [31:0] a0 = 32'h0, w0 = 32'h0;
        wr_addr.delete(); wr_data.delete();
        last_acc = -1; done_at = -1; req_run_max = 0;
        @(negedge clk);
        start_i = 1'b1; len_i = LW'(len);
        @(negedge clk);
        start_i = 1'b0; cyc = 1;
        n_tests++;
        if (busy_o !== (len > 0 && len <= MAXW)) begin
            n_fail++;
            $display("FAIL start_busy len=%0d: busy_o=%b done_o=%b", len, busy_o, done_o);
        end
        while (cyc < 3000) begin
            if (done_o === 1'b1) begin
                done_at = cyc;
                break;
            end
            start_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; illegal_i = 1'b0; byte_valid_i = 1'b0;
            if (rv_pend) begin
                rvalid_i = 1'b1; rv_pend = 1'b0;
            end else if (spur_rv && byte_ready_o && $urandom_range(0, 3) == 0) begin
                rvalid_i = 1'b1;
            end
            if (byte_ready_o) begin
                if (sent < stream.size() && $urandom_range(0, 99) >= bubble_pct) begin
                    byte_valid_i = 1'b1; byte_data_i = stream[sent]; sent++; last_acc = cyc + 1;
                end else begin
                    byte_data_i = 8'($urandom_range(0, 255));
                end
                if (busy_start && sent == 2) begin
                    start_i = 1'b1; len_i = LW'(7);
                end
            end
            if (req_o) begin
                req_run++;
                if (req_run > req_run_max) req_run_max = req_run;
                n_tests++;
                if (byte_ready_o !== 1'b0 || we_o !== 1'b1 || be_o !== 4'hF) begin
                    n_fail++;
                    $display("FAIL req_sideband: byte_ready_o=%b we_o=%b be_o=%h need 0,1,f",
                             byte_ready_o, we_o, be_o);
                end
                if (d < 0) begin
                    d = $urandom_range(gmax, gmin); a0 = addr_o; w0 = wdata_o;
                end else begin
                    n_tests++;
                    if (addr_o !== a0 || wdata_o !== w0) begin
                        n_fail++;
                        $display("FAIL req_stable: addr=%h data=%h need addr=%h data=%h",
                                 addr_o, wdata_o, a0, w0);
                    end
                end
                if (d == 0) begin
                    gnt_i = 1'b1; illegal_i = (grants == ill_word);
                    wr_addr.push_back(addr_o); wr_data.push_back(wdata_o);
                    grants++; rv_pend = 1'b1; d = -1;
                end else begin
                    d--;
                end
            end else begin
                req_run = 0;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; illegal_i = 1'b0; byte_valid_i = 1'b0;
        if (done_at < 0) begin
            n_tests++; n_fail++;
            $display("FAIL load_timeout len=%0d: done_o=%b need 1 within 3000 cycles", len, done_o);
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if (byte_ready_o !== 1'b0 || req_o !== 1'b0 || we_o !== 1'b0 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || err_o !== 1'b0 || count_o !== '0 || wdata_o !== 32'h0 ||
            addr_o !== BASE || be_o !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b req=%b we=%b busy=%b done=%b err=%b cnt=%0d wd=%h ad=%h be=%h",
                     byte_ready_o, req_o, we_o, busy_o, done_o, err_o, count_o, wdata_o, addr_o, be_o);
        end
    endtask

    task automatic test_single_word;
        stream.delete();
        stream.push_back(8'h11); stream.push_back(8'h22); stream.push_back(8'h33); stream.push_back(8'h44);
        run_load(1, 0, 0, 0, -1, 1'b0, 1'b0);
        n_tests++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 32'h8000_0000 || wr_data[0] !== 32'h4433_2211) begin
            n_fail++;
            $display("FAIL single_write: n=%0d addr=%h data=%h need 1 80000000 44332211",
                     wr_addr.size(), wr_addr[0], wr_data[0]);
        end
        n_tests++;
        if (done_at - last_acc !== 2 || count_o !== LW'(1) || err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: lat=%0d cnt=%0d err=%b busy=%b need 2 1 0 0",
                     done_at - last_acc, count_o, err_o, busy_o);
        end
    endtask

    task automatic test_stalled;
        fill_stream(12);
        ref_model(3, -1);
        run_load(3, 50, 0, 0, -1, 1'b0, 1'b0);
        n_tests++;
        if (wr_addr.size() !== exp_n || count_o !== LW'(exp_count) || req_run_max !== 1) begin
            n_fail++;
            $display("FAIL stalled_summary: writes=%0d cnt=%0d reqrun=%0d need %0d %0d 1",
                     wr_addr.size(), count_o, req_run_max, exp_n, exp_count);
        end
        for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
            n_tests++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL stalled_write%0d: %h/%h need %h/%h", i, wr_addr[i], wr_data[i],
                         exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_delayed_grant;
        fill_stream(4);
        ref_model(1, -1);
        run_load(1, 0, 5, 5, -1, 1'b0, 1'b0);
        n_tests++;
        if (req_run_max !== 6 || wr_addr.size() !== 1 || wr_data[0] !== exp_data[0] ||
            count_o !== LW'(1)) begin
            n_fail++;
            $display("FAIL delayed_grant: reqrun=%0d writes=%0d data=%h cnt=%0d need 6 1 %h 1",
                     req_run_max, wr_addr.size(), wr_data[0], count_o, exp_data[0]);
        end
    endtask

    task automatic test_len_edges;
        fill_stream(0);
        run_load(0, 0, 0, 0, -1, 1'b0, 1'b0);
        n_tests++;
        if (done_at !== 1 || err_o !== 1'b0 || wr_addr.size() !== 0 || count_o !== '0) begin
            n_fail++;
            $display("FAIL len_zero: done_at=%0d err=%b writes=%0d cnt=%0d need 1 0 0 0",
                     done_at, err_o, wr_addr.size(), count_o);
        end
        run_load(MAXW + 1, 0, 0, 0, -1, 1'b0, 1'b0);
        n_tests++;
        if (err_o !== 1'b1 || done_o !== 1'b1 || wr_addr.size() !== 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL len_over: err=%b done=%b writes=%0d busy=%b need 1 1 0 0",
                     err_o, done_o, wr_addr.size(), busy_o);
        end
    endtask

    task automatic test_illegal;
        fill_stream(16);
        ref_model(4, 1);
        run_load(4, 10, 0, 2, 1, 1'b0, 1'b0);
        n_tests++;
        if (err_o !== exp_err || count_o !== LW'(exp_count) || wr_addr.size() !== exp_n ||
            wr_addr[1] !== exp_addr[1]) begin
            n_fail++;
            $display("FAIL illegal: err=%b cnt=%0d writes=%0d need %b %0d %0d",
                     err_o, count_o, wr_addr.size(), exp_err, exp_count, exp_n);
        end
    endtask

    task automatic test_reset_restart;
        int guard = 0;
        fill_stream(8);
        @(negedge clk);
        start_i = 1'b1; len_i = LW'(2);
        @(negedge clk);
        start_i = 1'b0;
        while (!req_o && guard < 50) begin
            byte_valid_i = 1'b1; byte_data_i = 8'($urandom_range(1, 255));
            @(negedge clk);
            guard++;
        end
        byte_valid_i = 1'b0;
        n_tests++;
        if (req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_reach_req: req_o=%b need 1", req_o);
        end
        rst_ni = 1'b0;
        @(negedge clk);
        test_reset();
        rst_ni = 1'b1;
        fill_stream(28);
        ref_model(1, -1);
        run_load(1, 0, 0, 1, -1, 1'b0, 1'b1);
        n_tests++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 32'h8000_0000 || wr_data[0] !== exp_data[0] ||
            count_o !== LW'(1)) begin
            n_fail++;
            $display("FAIL restart_load: writes=%0d addr=%h data=%h cnt=%0d need 1 80000000 %h 1",
                     wr_addr.size(), wr_addr[0], wr_data[0], count_o, exp_data[0]);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 12; it++) begin
            int len = $urandom_range(1, 8);
            int ill = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            fill_stream(4 * len);
            ref_model(len, ill);
            run_load(len, $urandom_range(0, 60), 0, 3, ill, 1'b1, 1'b0);
            n_tests++;
            if (wr_addr.size() !== exp_n || count_o !== LW'(exp_count) || err_o !== exp_err) begin
                n_fail++;
                $display("FAIL random%0d_summary: writes=%0d cnt=%0d err=%b need %0d %0d %b",
                         it, wr_addr.size(), count_o, err_o, exp_n, exp_count, exp_err);
            end
            for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
                n_tests++;
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL random%0d_write%0d: %h/%h need %h/%h", it, i, wr_addr[i],
                             wr_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_ni = 1'b1;
        test_single_word();
        test_stalled();
        test_delayed_grant();
        test_len_edges();
        test_illegal();
        test_reset_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
